gauss_window_reader: RTL and testbench
======================================

Name: gauss_window_reader

Overview:
- Reader side of the 6x6 Gaussian tile buffer.
- Waits for the buffer's full indication, then snapshots the whole 6x6x8 tile.
- Streams all 3x3 windows of the snapshot in raster order to the convolution stage over a valid/ready handshake.
- Pulses tile_done so the writer can start refilling the buffer while windows are still being emitted.

Parameters:
- TILE_DIM, 6, tile edge length in pixels.
- WIN_DIM, 3, window edge length in pixels.
- PIX_W, 8, bits per pixel.
- Derived: NPOS = TILE_DIM-WIN_DIM+1 = 4 window origins per axis; CW = $clog2(NPOS) = 2.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- full  in  1  buffer holds a complete tile.
- buffer_in  in  [TILE_DIM-1:0][TILE_DIM-1:0][PIX_W-1:0]  tile, indexed [x][y].
- window_ready  in  1  consumer accepts the window.
- window_valid  out  1  window_out is valid.
- window_out  out  [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0]  window, indexed [i][j] = snapshot[win_x+i][win_y+j].
- win_x  out  CW  window origin x.
- win_y  out  CW  window origin y.
- last  out  1  current window is the final one, (NPOS-1,NPOS-1).
- tile_done  out  1  one-cycle pulse: tile captured, buffer may be refilled.
- busy  out  1  high while the state is not IDLE.

Behaviour:
- Reset values (asynchronous, active while n_rst=0):
  - state=IDLE, armed=1, snapshot=0, win_x=0, win_y=0.
  - window_valid=0, last=0, tile_done=0, busy=0, window_out=0.
- State IDLE:
  - If full=1 and armed=1 at a rising edge: load the snapshot from buffer_in, clear armed, clear win_x/win_y, go to EMIT.
  - If full=0 at a rising edge, set armed=1.
  - Stale-tile rule: a full held high across passes never starts a second pass; full must be seen low in IDLE before the next capture.
- tile_done:
  - Registered output, high for exactly the one cycle following the capture edge.
- State EMIT:
  - window_valid=1 and busy=1.
  - window_out, win_x, win_y and last are driven combinationally from the snapshot and counter registers only, never from buffer_in.
- Latency: the first window is valid in the cycle after the capture edge.
- Transfer: occurs on a rising edge where window_valid & window_ready.
  - win_x increments.
  - When win_x = NPOS-1 it wraps to 0 and win_y increments.
- Backpressure:
  - With window_ready=0, all outputs hold stable and the counters do not move.
  - window_valid never drops without a transfer.
- full and buffer_in are ignored during EMIT. The snapshot is immutable until the next capture.
- last=1 only when window_valid=1 and win_x=win_y=NPOS-1.
- Transfer of the last window:
  - Go to IDLE; window_valid=0 and busy=0 in the next cycle.
  - armed updates from full from that edge on.
- Throughput: 16 windows in exactly 16 cycles when window_ready is held high.
- Reset mid-operation: outputs drop immediately. After release the block is in IDLE with armed=1, so a still-full buffer is re-read from window (0,0).
- No arithmetic. Indices are unsigned; win_x+i ≤ 5 always.

Decomposition:
- Package gauss_pkg:
  - TILE_DIM, WIN_DIM, PIX_W, NPOS.
  - Typedefs pixel_t, tile_t ([5:0][5:0] pixel_t), window_t ([2:0][2:0] pixel_t).
  - State enum {IDLE, EMIT}.
- Sub-module gauss_window_mux: purely combinational 3x3 extract from tile_t given win_x/win_y. Reused by the convolution bench model.

Test Plan:
1. Reset: assert n_rst=0 mid-clock -> all outputs 0 immediately, busy=0.
2. Full pass: load buffer_in[x][y] = 6x+y+1; pulse full=1 for one cycle; hold window_ready=1 ->
   - tile_done pulses once.
   - 16 consecutive valid cycles in order (0,0),(1,0),…,(3,3).
   - First window: [0][0]=1, [2][2]=15.
   - Last window: last=1, [0][0]=22, [2][2]=36.
   - Then window_valid=0.
3. Backpressure: drop window_ready for 5 cycles while at (2,1) -> window_valid=1, win_x=2, win_y=1, window_out[0][0]=14 stable. Resume -> next is (3,1).
4. Stale tile: hold full=1 for 40 cycles -> exactly one pass, one tile_done. Drop full for 1 cycle, raise again -> second pass starts.
5. Snapshot isolation: during EMIT, rewrite buffer_in to all 8'hFF and toggle full -> remaining windows still match the original tile.
6. Mid-stream reset: assert n_rst at (1,2), release with full=1 -> capture on the first edge, restart from (0,0), 16 windows emitted.

Source files
------------

// File: rtl/gauss_pkg.sv
// Shared types and geometry for the 6x6 Gaussian tile buffer and its window reader.
// Window origins run 0..NPOS-1 on each axis, so origin+offset always stays inside the tile.
package gauss_pkg;
    localparam int TILE_DIM = 6;
    localparam int WIN_DIM  = 3;
    localparam int PIX_W    = 8;
    localparam int NPOS     = TILE_DIM - WIN_DIM + 1;
    localparam int CW       = $clog2(NPOS);
    localparam int IW       = $clog2(TILE_DIM);

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [TILE_DIM-1:0][TILE_DIM-1:0] tile_t;
    typedef pixel_t [WIN_DIM-1:0][WIN_DIM-1:0] window_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/gauss_window_reader_if.sv
// Tile-in / window-out bundle between the tile buffer, the window reader and the convolution stage.
// master is the reader side; slave is the buffer plus consumer side.
interface gauss_window_reader_if;
    import gauss_pkg::*;

    logic               full;
    tile_t              buffer_in;
    logic               window_ready;
    logic               window_valid;
    window_t            window_out;
    logic [CW-1:0]      win_x;
    logic [CW-1:0]      win_y;
    logic               last;
    logic               tile_done;
    logic               busy;

    modport master (
        input  full, buffer_in, window_ready,
        output window_valid, window_out, win_x, win_y, last, tile_done, busy
    );

    modport slave (
        output full, buffer_in, window_ready,
        input  window_valid, window_out, win_x, win_y, last, tile_done, busy
    );
endinterface

// File: rtl/gauss_window_mux.sv
// 3x3 window extract from a tile at origin (win_x, win_y); out[i][j] = tile[win_x+i][win_y+j].
// Purely combinational, zero latency, no flow control.
module gauss_window_mux
    import gauss_pkg::*;
(
    input  tile_t           tile,
    input  logic [CW-1:0]   win_x,
    input  logic [CW-1:0]   win_y,
    output window_t         window
);
    always_comb begin
        window = '0;
        for (int i = 0; i < WIN_DIM; i++) begin
            for (int j = 0; j < WIN_DIM; j++) begin
                window[i][j] = tile[IW'(win_x) + IW'(i)][IW'(win_y) + IW'(j)];
            end
        end
    end
endmodule

// File: rtl/gauss_window_reader.sv
// Snapshots a full 6x6 tile, then streams its 16 3x3 windows in raster order (x fastest).
// First window valid one cycle after capture; window_ready=0 freezes all outputs and counters.
module gauss_window_reader
    import gauss_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_rst,
    gauss_window_reader_if.master   bus
);
    state_t         state, state_nxt;
    tile_t          snapshot;
    logic           armed;
    logic [CW-1:0]  cnt_x, cnt_y;
    logic           tile_done_q;
    window_t        win_mux;
    logic           capture, xfer, at_end;

    // armed blocks a full that never dropped from re-triggering a second pass on the same tile
    assign capture = (state == IDLE) && bus.full && armed;
    assign xfer    = (state == EMIT) && bus.window_ready;
    assign at_end  = (cnt_x == CW'(NPOS-1)) && (cnt_y == CW'(NPOS-1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture)          state_nxt = EMIT;
            EMIT:    if (xfer && at_end)   state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            snapshot    <= '0;
            armed       <= 1'b1;
            cnt_x       <= '0;
            cnt_y       <= '0;
            tile_done_q <= 1'b0;
        end else begin
            tile_done_q <= capture;
            if (capture) begin
                snapshot <= bus.buffer_in;
                armed    <= 1'b0;
                cnt_x    <= '0;
                cnt_y    <= '0;
            end else if ((state == IDLE) && !bus.full) begin
                armed    <= 1'b1;
            end
            if (xfer) begin
                if (cnt_x == CW'(NPOS-1)) begin
                    cnt_x <= '0;
                    cnt_y <= cnt_y + CW'(1);
                end else begin
                    cnt_x <= cnt_x + CW'(1);
                end
            end
        end
    end

    gauss_window_mux u_mux (
        .tile   (snapshot),
        .win_x  (cnt_x),
        .win_y  (cnt_y),
        .window (win_mux)
    );

    always_comb begin
        bus.window_valid = (state == EMIT);
        bus.busy         = (state == EMIT);
        bus.last         = (state == EMIT) && at_end;
        bus.window_out   = (state == EMIT) ? win_mux : '0;
        bus.win_x        = cnt_x;
        bus.win_y        = cnt_y;
        bus.tile_done    = tile_done_q;
    end
endmodule

// File: tb/tb_gauss_window_reader.sv
// Bench for gauss_window_reader: random tiles and ready patterns against a tile-array reference.
module tb_gauss_window_reader;
    import gauss_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int unsigned ref_tile [TILE_DIM][TILE_DIM];

    always #5 clk = ~clk;

    gauss_window_reader_if bus();

    gauss_window_reader dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    function automatic tile_t pack_ref();
        tile_t t;
        for (int x = 0; x < TILE_DIM; x++)
            for (int y = 0; y < TILE_DIM; y++)
                t[x][y] = PIX_W'(ref_tile[x][y]);
        return t;
    endfunction

    function automatic window_t model_win(int x, int y);
        window_t w;
        for (int i = 0; i < WIN_DIM; i++)
            for (int j = 0; j < WIN_DIM; j++)
                w[i][j] = PIX_W'(ref_tile[x+i][y+j]);
        return w;
    endfunction

    task automatic fill_ramp();
        for (int x = 0; x < TILE_DIM; x++)
            for (int y = 0; y < TILE_DIM; y++)
                ref_tile[x][y] = 6*x + y + 1;
    endtask

    task automatic fill_random();
        for (int x = 0; x < TILE_DIM; x++)
            for (int y = 0; y < TILE_DIM; y++)
                ref_tile[x][y] = $urandom_range(0, 255);
    endtask

    task automatic idle_cycles(int n);
        bus.full = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({bus.window_valid, bus.busy, bus.last, bus.tile_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: valid/busy/last/done=%b want 0000",
                     {bus.window_valid, bus.busy, bus.last, bus.tile_done});
        end
        n_checks++;
        if (bus.window_out !== '0 || bus.win_x !== '0 || bus.win_y !== '0) begin
            n_fail++;
            $display("FAIL reset_data: win=%h x=%0d y=%0d want 0", bus.window_out, bus.win_x, bus.win_y);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.window_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: valid=%b busy=%b want 0 0", bus.window_valid, bus.busy);
        end
    endtask

    task automatic test_full_pass();
        int td = 0;
        int x, y;
        fill_ramp();
        bus.buffer_in = pack_ref();
        bus.window_ready = 1'b1;
        bus.full = 1'b1;
        @(negedge clk);
        bus.full = 1'b0;
        for (int k = 0; k < NPOS*NPOS; k++) begin
            if (k > 0) @(negedge clk);
            x = k % NPOS;
            y = k / NPOS;
            if (bus.tile_done === 1'b1) td++;
            n_checks++;
            if (bus.window_valid !== 1'b1 || bus.busy !== 1'b1 || bus.win_x !== CW'(x) || bus.win_y !== CW'(y)) begin
                n_fail++;
                $display("FAIL pass_pos k=%0d: valid=%b busy=%b x=%0d y=%0d want 1 1 %0d %0d",
                         k, bus.window_valid, bus.busy, bus.win_x, bus.win_y, x, y);
            end
            n_checks++;
            if (bus.window_out !== model_win(x, y) || bus.last !== (k == NPOS*NPOS-1)) begin
                n_fail++;
                $display("FAIL pass_win k=%0d: win=%h last=%b want %h %b",
                         k, bus.window_out, bus.last, model_win(x, y), (k == NPOS*NPOS-1));
            end
            if (k == 0) begin
                n_checks++;
                if (bus.tile_done !== 1'b1 || bus.window_out[0][0] !== 8'd1 || bus.window_out[2][2] !== 8'd15) begin
                    n_fail++;
                    $display("FAIL pass_first: done=%b w00=%0d w22=%0d want 1 1 15",
                             bus.tile_done, bus.window_out[0][0], bus.window_out[2][2]);
                end
            end
            if (k == NPOS*NPOS-1) begin
                n_checks++;
                if (bus.window_out[0][0] !== 8'd22 || bus.window_out[2][2] !== 8'd36) begin
                    n_fail++;
                    $display("FAIL pass_last: w00=%0d w22=%0d want 22 36",
                             bus.window_out[0][0], bus.window_out[2][2]);
                end
            end
        end
        @(negedge clk);
        if (bus.tile_done === 1'b1) td++;
        n_checks++;
        if (bus.window_valid !== 1'b0 || bus.busy !== 1'b0 || td != 1) begin
            n_fail++;
            $display("FAIL pass_end: valid=%b busy=%b tile_done_pulses=%0d want 0 0 1",
                     bus.window_valid, bus.busy, td);
        end
    endtask

    task automatic test_backpressure();
        int got = 0;
        int cyc = 0;
        int stall = 0;
        logic r;
        idle_cycles(2);
        fill_ramp();
        bus.buffer_in = pack_ref();
        bus.window_ready = 1'b1;
        bus.full = 1'b1;
        @(negedge clk);
        bus.full = 1'b0;
        while (got < NPOS*NPOS && cyc < 300) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            n_checks++;
            if (bus.window_valid !== 1'b1 || bus.win_x !== CW'(got % NPOS) || bus.win_y !== CW'(got / NPOS) ||
                bus.window_out !== model_win(got % NPOS, got / NPOS)) begin
                n_fail++;
                $display("FAIL bp_win idx=%0d: valid=%b x=%0d y=%0d win=%h want 1 %0d %0d %h", got,
                         bus.window_valid, bus.win_x, bus.win_y, bus.window_out,
                         got % NPOS, got / NPOS, model_win(got % NPOS, got / NPOS));
            end
            if (got == 6 && stall > 0 && stall <= 5) begin
                n_checks++;
                if (bus.win_x !== 2'd2 || bus.win_y !== 2'd1 || bus.window_out[0][0] !== 8'd14) begin
                    n_fail++;
                    $display("FAIL bp_hold: x=%0d y=%0d w00=%0d want 2 1 14",
                             bus.win_x, bus.win_y, bus.window_out[0][0]);
                end
            end
            if (got == 7 && stall == 6) begin
                n_checks++;
                stall++;
                if (bus.win_x !== 2'd3 || bus.win_y !== 2'd1) begin
                    n_fail++;
                    $display("FAIL bp_resume: x=%0d y=%0d want 3 1", bus.win_x, bus.win_y);
                end
            end
            if (got == 6 && stall < 5) begin
                r = 1'b0;
                stall++;
            end else if (got == 6) begin
                r = 1'b1;
                stall = 6;
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            bus.window_ready = r;
            if (r) got++;
        end
        n_checks++;
        if (got < NPOS*NPOS) begin
            n_fail++;
            $display("FAIL bp_timeout: windows=%0d want 16", got);
        end
        @(negedge clk);
        n_checks++;
        if (bus.window_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: valid=%b want 0", bus.window_valid);
        end
    endtask

    task automatic test_stale_tile();
        int td = 0;
        int idx = 0;
        int got = 0;
        int cyc = 0;
        logic r;
        idle_cycles(2);
        fill_random();
        bus.buffer_in = pack_ref();
        bus.window_ready = 1'b1;
        bus.full = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.tile_done === 1'b1) td++;
            if (bus.window_valid === 1'b1) begin
                n_checks++;
                if (idx >= NPOS*NPOS || bus.window_out !== model_win(idx % NPOS, idx / NPOS)) begin
                    n_fail++;
                    $display("FAIL stale_win idx=%0d: win=%h (second pass or wrong data)", idx, bus.window_out);
                end
                idx++;
            end
        end
        n_checks++;
        if (td != 1 || idx != NPOS*NPOS) begin
            n_fail++;
            $display("FAIL stale_count: tile_done=%0d windows=%0d want 1 16", td, idx);
        end
        fill_random();
        bus.buffer_in = pack_ref();
        bus.full = 1'b0;
        @(negedge clk);
        bus.full = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.tile_done !== 1'b1 || bus.window_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_rearm: done=%b valid=%b want 1 1", bus.tile_done, bus.window_valid);
        end
        while (got < NPOS*NPOS && cyc < 300) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            n_checks++;
            if (bus.window_valid !== 1'b1 || bus.win_x !== CW'(got % NPOS) || bus.win_y !== CW'(got / NPOS) ||
                bus.window_out !== model_win(got % NPOS, got / NPOS)) begin
                n_fail++;
                $display("FAIL stale_pass2 idx=%0d: valid=%b x=%0d y=%0d win=%h want %h", got,
                         bus.window_valid, bus.win_x, bus.win_y, bus.window_out, model_win(got % NPOS, got / NPOS));
            end
            r = 1'($urandom_range(0, 1));
            bus.window_ready = r;
            if (r) got++;
        end
        n_checks++;
        if (got < NPOS*NPOS) begin
            n_fail++;
            $display("FAIL stale_timeout: windows=%0d want 16", got);
        end
    endtask

    task automatic test_snapshot_isolation();
        int got = 0;
        int cyc = 0;
        logic r;
        idle_cycles(2);
        fill_random();
        bus.buffer_in = pack_ref();
        bus.full = 1'b1;
        @(negedge clk);
        bus.full = 1'b0;
        while (got < NPOS*NPOS && cyc < 300) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            n_checks++;
            if (bus.window_valid !== 1'b1 || bus.win_x !== CW'(got % NPOS) || bus.win_y !== CW'(got / NPOS) ||
                bus.window_out !== model_win(got % NPOS, got / NPOS)) begin
                n_fail++;
                $display("FAIL iso_win idx=%0d: valid=%b x=%0d y=%0d win=%h want %h", got,
                         bus.window_valid, bus.win_x, bus.win_y, bus.window_out, model_win(got % NPOS, got / NPOS));
            end
            r = 1'($urandom_range(0, 1));
            bus.window_ready = r;
            if (r) got++;
            if (got >= 3) bus.buffer_in = {TILE_DIM*TILE_DIM{8'hFF}};
            bus.full = (got >= 3 && got < NPOS*NPOS) ? ~bus.full : 1'b0;
        end
        n_checks++;
        if (got < NPOS*NPOS) begin
            n_fail++;
            $display("FAIL iso_timeout: windows=%0d want 16", got);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (bus.window_valid !== 1'b0 || bus.tile_done !== 1'b0) begin
                n_fail++;
                $display("FAIL iso_idle: valid=%b done=%b want 0 0", bus.window_valid, bus.tile_done);
            end
        end
    endtask

    task automatic test_mid_reset();
        idle_cycles(2);
        fill_random();
        bus.buffer_in = pack_ref();
        bus.window_ready = 1'b1;
        bus.full = 1'b1;
        for (int k = 0; k <= 9; k++) @(negedge clk);
        n_checks++;
        if (bus.win_x !== 2'd1 || bus.win_y !== 2'd2 || bus.window_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mrst_pos: valid=%b x=%0d y=%0d want 1 1 2", bus.window_valid, bus.win_x, bus.win_y);
        end
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.window_valid, bus.busy, bus.last, bus.tile_done} !== 4'b0000 ||
            bus.window_out !== '0 || bus.win_x !== '0 || bus.win_y !== '0) begin
            n_fail++;
            $display("FAIL mrst_drop: flags=%b win=%h x=%0d y=%0d want all 0",
                     {bus.window_valid, bus.busy, bus.last, bus.tile_done}, bus.window_out, bus.win_x, bus.win_y);
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < NPOS*NPOS; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_checks++;
                if (bus.tile_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mrst_capture: done=%b want 1", bus.tile_done);
                end
            end
            n_checks++;
            if (bus.window_valid !== 1'b1 || bus.win_x !== CW'(k % NPOS) || bus.win_y !== CW'(k / NPOS) ||
                bus.window_out !== model_win(k % NPOS, k / NPOS)) begin
                n_fail++;
                $display("FAIL mrst_win k=%0d: valid=%b x=%0d y=%0d win=%h want %h", k,
                         bus.window_valid, bus.win_x, bus.win_y, bus.window_out, model_win(k % NPOS, k / NPOS));
            end
        end
        bus.full = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.window_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_end: valid=%b want 0", bus.window_valid);
        end
    endtask

    initial begin
        bus.full = 1'b0;
        bus.window_ready = 1'b0;
        bus.buffer_in = '0;
        test_reset();
        test_full_pass();
        test_backpressure();
        test_stale_tile();
        test_snapshot_isolation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
